// File: rtl/bitonic_frame_buffer_pkg.sv
// Shared types and helpers for the bitonic frame buffer: FSM states,
// sort-direction encodings and the pad value that sorts behind all real keys.
package bitonic_frame_buffer_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRAIN  = 2'd2
  } bfb_state_e;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

  localparam int PAD_MAXW = 64;

  // Ascending frames pad with all-ones, descending with all-zeros, so pads
  // always land after the real keys.
  function automatic logic [PAD_MAXW-1:0] pad_value(input logic dir, input int w);
    logic [PAD_MAXW-1:0] m;
    m = '0;
    for (int b = 0; b < PAD_MAXW; b++)
      if (b < w) m[b] = 1'b1;
    return (dir == DIR_ASC) ? m : '0;
  endfunction

endpackage

// File: rtl/bitonic_frame_serializer.sv
// Holds the sorted vector captured from the network and streams the first
// nvalid keys out over a valid/ready handshake.
module bitonic_frame_serializer
  import bitonic_frame_buffer_pkg::*;
#(
  parameter int NUM = 16,
  parameter int W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   load_i,
  input  logic [NUM*W-1:0]       vec_i,
  input  logic [$clog2(NUM):0]   nvalid_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [W-1:0]           out_data_o,
  output logic                   out_last_o
);

  localparam int CW = $clog2(NUM);

  logic [NUM-1:0][W-1:0] vec_q;
  logic [CW-1:0]         idx_q;
  logic [CW:0]           nvalid_q;
  logic                  valid_q;
  logic                  last;

  assign last        = valid_q && ({1'b0, idx_q} == (nvalid_q - 1'b1));
  assign out_valid_o = valid_q;
  assign out_last_o  = last;
  assign out_data_o  = vec_q[idx_q];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vec_q    <= '0;
      idx_q    <= '0;
      nvalid_q <= '0;
      valid_q  <= 1'b0;
    end else if (load_i) begin
      vec_q    <= vec_i;
      idx_q    <= '0;
      nvalid_q <= nvalid_i;
      valid_q  <= 1'b1;
    end else if (valid_q && out_ready_i) begin
      // Sorted slots stay put after the frame; only valid drops.
      if (last) valid_q <= 1'b0;
      else      idx_q   <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/bitonic_frame_buffer.sv
// Frame assembler around an external combinational bitonic network: fills up to
// NUM keys, pads, waits for the network to settle, then drains sorted keys.
module bitonic_frame_buffer
  import bitonic_frame_buffer_pkg::*;
#(
  parameter int NUM    = 16,
  parameter int W      = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_data_i,
  input  logic             in_last_i,
  input  logic             in_dir_i,
  output logic             net_dir_o,
  output logic [NUM*W-1:0] net_in_o,
  input  logic [NUM*W-1:0] net_out_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     out_data_o,
  output logic             out_last_o,
  output logic             busy_o
);

  localparam int CW = $clog2(NUM);

  bfb_state_e            state_q;
  logic [NUM-1:0][W-1:0] slot_q;
  logic [CW:0]           count_q;
  logic [CW:0]           count_d;
  logic [CW:0]           nvalid_q;
  logic                  net_dir_q;
  logic [SETTLE:0]       vld_pipe_q;

  logic                  accept;
  logic                  close;
  logic                  eff_dir;
  logic [W-1:0]          pad_w;
  logic                  load;
  logic                  drain_done;

  assign accept  = (state_q == ST_FILL) && in_valid_i;
  assign close   = in_last_i || (count_q == (CW+1)'(NUM-1));
  assign count_d = count_q + 1'b1;
  // The closing key may also be the first one, so pad from the direction
  // being latched on this same edge.
  assign eff_dir = (count_q == '0) ? in_dir_i : net_dir_q;
  assign pad_w   = W'(pad_value(eff_dir, W));

  // Closing accept launches a token that reaches the top after SETTLE+1 edges.
  assign load       = (state_q == ST_SETTLE) && vld_pipe_q[SETTLE];
  assign drain_done = out_valid_o && out_ready_i && out_last_o;

  assign in_ready_o = (state_q == ST_FILL);
  assign busy_o     = !((state_q == ST_FILL) && (count_q == '0));
  assign net_in_o   = slot_q;
  assign net_dir_o  = net_dir_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_FILL;
      slot_q     <= '0;
      count_q    <= '0;
      nvalid_q   <= '0;
      net_dir_q  <= DIR_ASC;
      vld_pipe_q <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            slot_q[count_q[CW-1:0]] <= in_data_i;
            if (count_q == '0) net_dir_q <= in_dir_i;
            if (close) begin
              for (int j = 0; j < NUM; j++)
                if (j > int'(count_q)) slot_q[j] <= pad_w;
              nvalid_q   <= count_d;
              vld_pipe_q <= (SETTLE+1)'(1);
              state_q    <= ST_SETTLE;
            end else begin
              count_q <= count_d;
            end
          end
        end
        ST_SETTLE: begin
          if (load) begin
            vld_pipe_q <= '0;
            state_q    <= ST_DRAIN;
          end else begin
            vld_pipe_q <= {vld_pipe_q[SETTLE-1:0], 1'b0};
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            count_q <= '0;
            state_q <= ST_FILL;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  bitonic_frame_serializer #(
    .NUM (NUM),
    .W   (W)
  ) u_ser (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .load_i      (load),
    .vec_i       (net_out_i),
    .nvalid_i    (nvalid_q),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o)
  );

endmodule

// File: tb/tb_bitonic_frame_buffer.sv
// Directed bench for bitonic_frame_buffer with a behavioural sorting network
// standing in for BitonicNetwork.
module tb_bitonic_frame_buffer;

  localparam int NUM    = 16;
  localparam int W      = 16;
  localparam int SETTLE = 2;

  typedef logic [W-1:0] key_q_t[$];

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic             in_last = 1'b0;
  logic             in_dir = 1'b0;
  logic             net_dir;
  logic [NUM*W-1:0] net_in;
  logic [NUM*W-1:0] net_out;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_data;
  logic             out_last;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] got_d[$];
  logic         got_l[$];

  always #5 clk = ~clk;

  bitonic_frame_buffer #(.NUM(NUM), .W(W), .SETTLE(SETTLE)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_last_i(in_last), .in_dir_i(in_dir),
    .net_dir_o(net_dir), .net_in_o(net_in), .net_out_i(net_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .busy_o(busy)
  );

  function automatic logic [NUM*W-1:0] sort_vec(input logic [NUM*W-1:0] v, input logic d);
    logic [W-1:0] a [NUM];
    logic [W-1:0] t;
    logic [NUM*W-1:0] r;
    for (int i = 0; i < NUM; i++) a[i] = v[i*W +: W];
    for (int i = 0; i < NUM-1; i++)
      for (int j = 0; j < NUM-1-i; j++)
        if (d ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    r = '0;
    for (int i = 0; i < NUM; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  assign net_out = sort_vec(net_in, net_dir);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic send_key(input logic [W-1:0] k, input logic last, input logic dir);
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = k; in_last = last; in_dir = dir;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // First key carries the frame direction; later keys carry the opposite
  // direction, which must be ignored.
  task automatic send_frame(input key_q_t keys, input logic dir, input bit close_last);
    for (int i = 0; i < keys.size(); i++)
      send_key(keys[i], close_last && (i == keys.size()-1), (i == 0) ? dir : ~dir);
  endtask

  task automatic drain(input int n, input bit bp);
    int k, cyc;
    bit stalled;
    logic [W-1:0] held;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    k = 0; cyc = 0; stalled = 0; held = '0;
    got_d.delete(); got_l.delete();
    while (k < n && cyc < 200) begin
      @(negedge clk);
      if (stalled) chk("hold_data", 32'(out_data), 32'(held));
      out_ready = bp ? pat[cyc % 4] : 1'b1;
      cyc++;
      stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
        k++;
        if (k == n) chk("in_ready_busy", 32'(in_ready), 32'd0);
      end
    end
    if (k < n) chk("drain_timeout", 32'(k), 32'(n));
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input key_q_t exp, input bit bp);
    drain(exp.size(), bp);
    chk({tag, "_count"}, 32'(got_d.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(got_d[i]), 32'(exp[i]));
      chk($sformatf("%s_last%0d", tag, i), 32'(got_l[i]), 32'(i == exp.size()-1));
    end
    chk({tag, "_no_extra"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_net_dir"},   32'(net_dir),   32'd0);
    chk({tag, "_net_in"},    32'(net_in != '0), 32'd0);
  endtask

  initial begin
    key_q_t q, e;
    int lat;

    #12;
    chk_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // Full ascending frame closed by the 16th key, checks settle latency.
    q = {}; e = {};
    for (int k = 15; k >= 0; k--) q.push_back(W'(k));
    for (int k = 0; k < 16; k++)  e.push_back(W'(k));
    send_frame(q, 1'b0, 1'b0);
    chk("asc16_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("asc16_latency", 32'(lat), 32'd3);
    expect_frame("asc16", e, 1'b0);

    // Partial descending frame: zero pads must not appear.
    q = {16'd5, 16'd9, 16'd1};
    e = {16'd9, 16'd5, 16'd1};
    send_frame(q, 1'b1, 1'b1);
    chk("desc3_net_dir", 32'(net_dir), 32'd1);
    expect_frame("desc3", e, 1'b0);

    // Ascending frame with a key equal to the pad value.
    q = {16'hFFFF, 16'd3};
    e = {16'd3, 16'hFFFF};
    send_frame(q, 1'b0, 1'b1);
    expect_frame("padeq", e, 1'b0);

    // Backpressure during drain.
    q = {16'd4, 16'd2, 16'd8, 16'd6};
    e = {16'd2, 16'd4, 16'd6, 16'd8};
    send_frame(q, 1'b0, 1'b1);
    expect_frame("bp", e, 1'b1);

    // Full descending frame with in_last on the 16th key.
    q = {}; e = {};
    for (int k = 0; k < 16; k++)  q.push_back(W'(k * 3));
    for (int k = 15; k >= 0; k--) e.push_back(W'(k * 3));
    send_frame(q, 1'b1, 1'b1);
    expect_frame("desc16", e, 1'b0);
    chk("desc16_idle", 32'(busy), 32'd0);

    // Single-key frame, then back-to-back frame with new direction.
    q = {16'd7};
    e = {16'd7};
    send_frame(q, 1'b0, 1'b1);
    expect_frame("one", e, 1'b0);
    send_key(16'd1, 1'b0, 1'b1);
    chk("b2b_net_dir", 32'(net_dir), 32'd1);
    send_key(16'd2, 1'b1, 1'b0);
    e = {16'd2, 16'd1};
    expect_frame("b2b", e, 1'b0);

    // Reset in FILL after 6 keys.
    q = {16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16};
    send_frame(q, 1'b1, 1'b0);
    chk("fill6_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_fill");
    @(negedge clk); rst_n = 1'b1;
    q = {16'd3, 16'd1};
    e = {16'd1, 16'd3};
    send_frame(q, 1'b0, 1'b1);
    expect_frame("post_rst_fill", e, 1'b0);

    // Reset in DRAIN at idx 2.
    q = {16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
    send_frame(q, 1'b0, 1'b1);
    drain(2, 1'b0);
    chk("drain_idx2_data", 32'(out_data), 32'd30);
    chk("drain_idx2_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_drain");
    @(negedge clk); rst_n = 1'b1;
    q = {16'd10, 16'd20};
    e = {16'd20, 16'd10};
    send_frame(q, 1'b1, 1'b1);
    expect_frame("post_rst_drain", e, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/bitonic_frame_buffer.md
Name: bitonic_frame_buffer

Overview:
- Sequential front/back end wrapped around the combinational BitonicNetwork.
- Accepts a stream of W-bit keys, assembles up to NUM keys into one frame, and drives the frame and the latched sort direction onto the network.
- After a fixed settle interval, captures the sorted vector and streams the valid keys back out in sorted order.
- Sits between the scheduler's key producer and its priority consumer.

Parameters:
- NUM, 16, keys per frame (power of two, ≥2; matches BitonicNetwork NUM).
- W, 16, key width in bits (matches BitonicNetwork W).
- SETTLE, 2, clock cycles allowed for combinational network propagation (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  key present on in_data.
- in_ready  out  1  block can accept a key.
- in_data  in  W  key.
- in_last  in  1  marks the final key of a frame; closes a partial frame.
- in_dir  in  1  sort direction, 0 ascending, 1 descending; sampled with the first key of a frame.
- net_dir  out  1  latched direction to BitonicNetwork.direction.
- net_in  out  NUM*W  frame to BitonicNetwork.IN; slot i at [i*W +: W].
- net_out  in  NUM*W  sorted vector from BitonicNetwork.OUT.
- out_valid  out  1  sorted key present on out_data.
- out_ready  in  1  consumer accepts key.
- out_data  out  W  sorted key.
- out_last  out  1  final valid key of the frame.
- busy  out  1  high in any state other than FILL-with-zero-keys.

Behaviour:
- Reset (async assert, sync deassert at the consumer): state=FILL, count=0, net_in=0, net_dir=0, out register=0, out_valid=0, out_last=0, in_ready=1, busy=0.
- Reset mid-frame discards the frame. No partial output is emitted after reset.
- Handshakes: a transfer occurs on a clk edge with valid&ready. Once out_valid is asserted, out_data, out_valid and out_last hold stable until out_ready.
- FILL state: in_ready=1.
  - Each accepted key is written to slot count, and count increments.
  - When count=0, the same acceptance latches net_dir<=in_dir.
  - On acceptance with in_last=1, or when count reaches NUM-1 before increment (frame full), move to SETTLE.
  - On entry to SETTLE, pad slots count+1..NUM-1 (or none if full): all-ones when net_dir=0, all-zeros when net_dir=1. Pads therefore sort behind every real key.
  - Store nvalid = number of real keys, range 1..NUM, width $clog2(NUM)+1.
  - net_in reflects slot registers at all times.
- SETTLE state: in_ready=0.
  - A counter runs SETTLE cycles.
  - On the final cycle, capture net_out into the sorted register, set idx=0, and move to DRAIN.
- DRAIN state: in_ready=0, out_valid=1.
  - out_data = sorted slot idx; out_last=(idx==nvalid-1).
  - On each out transfer, idx increments.
  - A transfer with out_last moves to FILL with count=0 and slots unchanged.
  - No bubble cycle is required on the FILL→accept path.
- Latency: the first out_valid occurs SETTLE+1 cycles after the edge that accepted the closing key.
- Boundary cases:
  - in_last on the first key gives a 1-key frame: one output key with out_last=1.
  - A NUM-th key with in_last=0 still closes the frame.
  - in_last together with the NUM-th key closes the frame once; nothing is carried over.
  - in_valid while in_ready=0 is ignored; the producer must hold it.
  - in_dir is ignored except on the first key of a frame.
  - Keys equal to the pad value are legal. Output equals the correctly sorted multiset of real keys because pads only duplicate the extreme value.
- Throughput: no overlap between frames; in_ready stays 0 from the closing key until the last output transfer.

Decomposition:
- Shared package: state enum {FILL, SETTLE, DRAIN}, direction constants DIR_ASC=0 and DIR_DESC=1, and a pad-value function of (dir, W).
- Natural sub-module: bitonic_frame_serializer. It holds the captured vector, idx and nvalid, and runs the DRAIN out-handshake. The parent keeps the fill logic, the FSM and the settle counter.
- BitonicNetwork is instantiated by the integrating top, not inside this block.
- The bench instantiates both blocks.

Test Plan:
- Full ascending frame: NUM=16, W=16, dir=0, keys 16'h000F down to 16'h0000 with out_ready=1 → outputs 0x0000..0x000F in order. out_last is set on 0x000F. First out_valid occurs 3 cycles after the 16th accept.
- Partial descending frame: dir=1, keys 5,9,1 with in_last on 1 → outputs 9,5,1. out_last on 1. No zero pads emitted.
- Partial ascending frame with pad-equal key: keys 16'hFFFF, 3 with in_last → outputs 3, 0xFFFF. Exactly 2 transfers.
- Backpressure: toggle out_ready 1,0,0,1 during drain → out_data held while stalled. No key is lost or duplicated. in_ready stays 0 until the final transfer, then rises next cycle.
- Single key then back-to-back frame: key 7 with in_last → one output 7 with out_last. An immediate next frame with dir=1 latches the new direction.
- Reset mid-frame: rst_n low after 6 keys accepted in FILL, or in DRAIN at idx=2 → all outputs return to reset values asynchronously. The next frame sorts correctly with no stale keys.
